riscv_v_skid_stage: RTL and testbench
=====================================

Name: riscv_v_skid_stage

Overview:
- Elastic, handshaked pipeline stage for the vector datapath: a 2-entry skid buffer between a producer and a consumer using valid/ready.
- It is the consumer-facing counterpart of the enable-driven stage register. Instead of a global stall enable, back-pressure arrives on out_ready and is returned to the producer as registered in_ready.
- Full throughput (one beat per cycle) with no combinational path from out_ready to in_ready.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- RST_VAL, 0, value loaded into both payload registers on reset and on flush.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all held beats.
- in_valid  input  1  producer presents a beat.
- in_ready  output  1  stage can accept a beat; registered.
- data_in  input  DATA_WIDTH  producer payload.
- out_valid  output  1  stage presents a beat; registered.
- out_ready  input  1  consumer accepts a beat.
- data_out  output  DATA_WIDTH  payload of the oldest held beat; driven directly from the main register.
- count  output  2  occupancy: 0, 1 or 2.

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A beat transfers only on a rising clk edge where its fire term is 1.
- State register, 2 bits:
  - EMPTY: count=0, out_valid=0, in_ready=1.
  - HALF: count=1, out_valid=1, in_ready=1.
  - FULL: count=2, out_valid=1, in_ready=0.
- Outputs out_valid, in_ready and count are decoded only from the state register. There are no combinational input-to-output paths except data_out = main.
- Reset (rst_n=0, asynchronous, any time including mid-transfer):
  - State goes to EMPTY; main and skid are loaded with RST_VAL.
  - Outputs while in reset: out_valid=0, in_ready=1, count=0, data_out=RST_VAL.
  - First accept is possible on the first rising edge after rst_n deasserts.
- Transitions, when flush=0:
  - EMPTY: in_fire -> HALF, main<=data_in. Otherwise stay. Latency from in_fire to out_valid is 1 cycle.
  - HALF, in_fire & out_fire -> HALF, main<=data_in (pass-through at full rate).
  - HALF, in_fire & !out_fire -> FULL, skid<=data_in; main unchanged.
  - HALF, !in_fire & out_fire -> EMPTY.
  - HALF, neither fire -> hold.
  - FULL: in_fire is impossible because in_ready=0. out_fire -> HALF, main<=skid. Otherwise hold; data_out stays stable while out_valid & !out_ready.
- Flush (flush=1, synchronous):
  - Priority is below reset and above all handshake activity.
  - Next state is EMPTY; main and skid load RST_VAL.
  - A beat that fires on in_fire or out_fire in the flush cycle is discarded. The producer and consumer must treat a flush cycle as cancelling that transfer.
- Ordering: strictly FIFO. main always holds the older beat. No beat is duplicated or lost except by flush or reset.
- Stability rule: while out_valid=1 and out_ready=0, data_out and out_valid must not change, except via flush or reset.
- The skid register holds a meaningful value only in FULL; its content in other states is don't-care but must equal RST_VAL after reset or flush.
- Illegal states: the 2-bit state encoding value 3 must decode to EMPTY behaviour and return to EMPTY on the next edge.

Test Plan (DATA_WIDTH=8, RST_VAL=8'h00):
- Reset, then drive in_valid=1 with data 8'h11, 8'h22, 8'h33 on consecutive cycles while out_ready=1 -> out_valid rises 1 cycle after the first accept. data_out is 11, 22, 33 on consecutive cycles. in_ready stays 1 and count stays 1.
- Send 8'hA1, then 8'hA2 with out_ready=0 -> count becomes 1 then 2, in_ready=0, data_out holds A1. Raise out_ready for 2 cycles -> outputs A1 then A2, count goes 1 then 0, in_ready=1 after the first out_fire.
- With the stage FULL (A1, A2), assert flush for 1 cycle while in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, data_out=00. Neither A1 nor A2 reappears.
- With the stage HALF holding 8'h5C, pull rst_n low asynchronously between clock edges -> out_valid=0 and data_out=00 immediately. After release, accept 8'h77 -> data_out=77 one cycle later.
- Random in_valid and out_ready at 50% each for 1000 cycles with an incrementing payload -> the scoreboard sees a gap-free, in-order sequence. in_ready is never 1 while count=2, and out_valid never drops while out_ready=0 (flush held 0).
- Force the state register to encoding 3 -> out_valid=0 and in_ready=1, and the state is EMPTY after one edge.

Source files
------------

// File: rtl/riscv_v_skid_stage.sv
// rtl/riscv_v_skid_stage.sv - 2-entry valid/ready skid buffer for the vector datapath
//
// Purpose:
//   Elastic pipeline stage that runs at one beat per cycle. in_ready, out_valid
//   and count are decoded only from the state register, so out_ready never
//   reaches in_ready combinationally. data_out comes straight from the main
//   register, which always holds the oldest beat.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous discard of all held beats (beats firing this cycle are dropped)
//   in_valid   producer presents a beat
//   in_ready   stage can accept a beat (state decode)
//   data_in    producer payload
//   out_valid  stage presents a beat (state decode)
//   out_ready  consumer accepts a beat
//   data_out   payload of the oldest held beat
//   count      occupancy 0..2
module riscv_v_skid_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            count
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_HALF  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [DATA_WIDTH-1:0] w_main_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;
  logic                  w_in_fire;
  logic                  w_out_fire;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_main  <= RST_VAL;
      r_skid  <= RST_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Next state and payload steering. Flush overrides every handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = RST_VAL;
      w_skid_nxt  = RST_VAL;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = S_HALF;
            w_main_nxt  = data_in;
          end
        end
        S_HALF: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = data_in;
          end else if (w_in_fire) begin
            // Consumer stalled: park the younger beat behind main.
            w_state_nxt = S_FULL;
            w_skid_nxt  = data_in;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_nxt = S_HALF;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          // Unused encoding: recover to EMPTY on the next edge.
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // Output decode from the state register only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    count     = 2'd0;
    case (r_state)
      S_HALF: begin
        out_valid = 1'b1;
        count     = 2'd1;
      end
      S_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        count     = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        count     = 2'd0;
      end
    endcase
  end

  assign data_out = r_main;

endmodule

// File: tb/tb_riscv_v_skid_stage.sv
// tb/tb_riscv_v_skid_stage.sv - scoreboard bench for riscv_v_skid_stage
module tb_riscv_v_skid_stage;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic [1:0] count;

  int         n_cmp;
  int         n_bad;
  bit         mon_en;
  logic [7:0] q[$];

  riscv_v_skid_stage #(
    .DATA_WIDTH(8),
    .RST_VAL   (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of capacity two. Inputs are stable at the falling
  // edge, so the transfers that will happen on the next rising edge are known.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else if (mon_en) begin
      chk("count", int'(count), q.size());
      chk("in_ready", int'(in_ready), int'(q.size() < 2));
      chk("out_valid", int'(out_valid), int'(q.size() > 0));
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) begin
          chk("pop_data", int'(data_out), int'(q.pop_front()));
        end
        if (in_valid && in_ready) q.push_back(data_in);
      end
    end
  end

  initial begin
    logic [7:0] seq_val;
    logic       fired;
    n_cmp     = 0;
    n_bad     = 0;
    mon_en    = 1'b1;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = 8'h00;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_data", int'(data_out), 8'h00);
    step(); step();
    rst_n = 1'b1;

    // Full-rate pass-through.
    in_valid = 1'b1; out_ready = 1'b1; data_in = 8'h11;
    step();
    chk("pt_valid", int'(out_valid), 1);
    chk("pt_d11", int'(data_out), 8'h11);
    data_in = 8'h22;
    step();
    chk("pt_d22", int'(data_out), 8'h22);
    chk("pt_count", int'(count), 1);
    data_in = 8'h33;
    step();
    chk("pt_d33", int'(data_out), 8'h33);
    chk("pt_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    step();
    chk("pt_drain", int'(count), 0);

    // Fill under back-pressure then drain.
    out_ready = 1'b0; in_valid = 1'b1; data_in = 8'hA1;
    step();
    chk("bp_cnt1", int'(count), 1);
    data_in = 8'hA2;
    step();
    chk("bp_cnt2", int'(count), 2);
    chk("bp_ready0", int'(in_ready), 0);
    chk("bp_hold", int'(data_out), 8'hA1);
    in_valid = 1'b0;
    step();
    chk("bp_stable", int'(data_out), 8'hA1);
    out_ready = 1'b1;
    step();
    chk("dr_a2", int'(data_out), 8'hA2);
    chk("dr_cnt1", int'(count), 1);
    chk("dr_ready1", int'(in_ready), 1);
    step();
    chk("dr_cnt0", int'(count), 0);

    // Flush from FULL while both sides would fire.
    out_ready = 1'b0; in_valid = 1'b1; data_in = 8'hA1;
    step();
    data_in = 8'hA2;
    step();
    chk("fl_full", int'(count), 2);
    flush = 1'b1; out_ready = 1'b1; data_in = 8'hA3;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count", int'(count), 0);
    chk("fl_valid", int'(out_valid), 0);
    chk("fl_data", int'(data_out), 8'h00);
    step();
    chk("fl_gone", int'(out_valid), 0);

    // Asynchronous reset from HALF.
    out_ready = 1'b0; in_valid = 1'b1; data_in = 8'h5C;
    step();
    in_valid = 1'b0;
    chk("ar_half", int'(data_out), 8'h5C);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", int'(out_valid), 0);
    chk("ar_data", int'(data_out), 8'h00);
    chk("ar_count", int'(count), 0);
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; data_in = 8'h77;
    step();
    in_valid = 1'b0;
    chk("ar_d77", int'(data_out), 8'h77);
    chk("ar_v77", int'(out_valid), 1);
    step();

    // Random traffic with an incrementing payload.
    seq_val = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(1) == 1);
      out_ready = ($urandom_range(1) == 1);
      data_in   = seq_val;
      fired     = in_valid && in_ready;
      step();
      if (fired) seq_val = seq_val + 8'd1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("rnd_empty", int'(count), 0);
    chk("rnd_q", q.size(), 0);

    // Unused state encoding behaves as EMPTY and recovers.
    out_ready = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    force dut.r_state = 2'd3;
    #1;
    chk("ill_valid", int'(out_valid), 0);
    chk("ill_ready", int'(in_ready), 1);
    release dut.r_state;
    step();
    chk("ill_state", int'(dut.r_state), 0);
    chk("ill_count", int'(count), 0);
    step();
    mon_en = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
